masked_word_match_detector: RTL and testbench

Parametrised, registered successor to the team's fixed 6-bit equality comparator. It holds a loaded reference word and a don't-care mask, and compares a stream of valid-qualified input words against them. Four modes are supported: equal, not-equal, less-than and greater-than. It tracks consecutive hits and asserts a lock flag after a programmable run length, for use as a sync-word or pattern detector in front of lab datapaths.

---
 rtl/masked_word_match_detector.sv | 150 +++++++++++++++
 tb/tb_masked_word_match_detector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/masked_word_match_detector.sv
// masked_word_match_detector
//
// Compares a stream of valid-qualified words against a reference word that
// has been loaded together with a don't-care mask. It can be used as a
// sync-word or pattern detector. Results appear one cycle after a sample is
// accepted. The block counts consecutive hits in a saturating streak
// counter and asserts "locked" while the streak is at MATCH_COUNT. A
// saturating counter also tallies every hit since the last load or reset.
//
// Parameters:
//   WIDTH       - width of reference, mask and data words (>= 1)
//   MATCH_COUNT - consecutive hits required to assert locked (>= 1)
//   CNT_W       - width of the saturating total-hit counter
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   load_ref  in   capture ref_in/mask_in on this edge (wins over in_valid)
//   ref_in    in   reference word
//   mask_in   in   compare mask, 1 = bit compared, 0 = don't care
//   mode      in   00 eq, 01 ne, 10 data<ref, 11 data>ref (unsigned)
//   in_valid  in   data_in is valid this cycle
//   data_in   in   word under test
//   out_valid out  hit is valid (one cycle after an accepted sample)
//   hit       out  compare result of the last accepted sample
//   streak    out  consecutive-hit count, saturating at MATCH_COUNT
//   locked    out  high while streak == MATCH_COUNT
//   hit_count out  total hits since last load/reset, saturating

module masked_word_match_detector #(
  parameter int WIDTH       = 6,
  parameter int MATCH_COUNT = 3,
  parameter int CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_ref,
  input  logic [WIDTH-1:0]                     ref_in,
  input  logic [WIDTH-1:0]                     mask_in,
  input  logic [1:0]                           mode,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     data_in,
  output logic                                 out_valid,
  output logic                                 hit,
  output logic [$clog2(MATCH_COUNT+1)-1:0]     streak,
  output logic                                 locked,
  output logic [CNT_W-1:0]                     hit_count
);

  localparam int STREAK_W = $clog2(MATCH_COUNT + 1);
  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MATCH_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     ref_q;
  logic [WIDTH-1:0]     mask_q;
  logic                 out_valid_q;
  logic                 hit_q;
  logic                 locked_q;
  logic [STREAK_W-1:0]  streak_q;
  logic [STREAK_W-1:0]  streak_d;
  logic [CNT_W-1:0]     hit_count_q;
  logic [CNT_W-1:0]     hit_count_d;

  logic [WIDTH-1:0]     dm;
  logic [WIDTH-1:0]     rm;
  logic                 result;
  logic                 accept;

  // A sample is only taken once a reference exists. A load in the same
  // cycle takes priority, and the sample is dropped.
  assign accept = in_valid && !load_ref && (state_q != IDLE);

  // Masked compare. Bits outside the mask are forced to zero on both
  // operands. With an all-zero mask, eq therefore always hits and ne/lt/gt
  // never hit.
  always_comb begin
    dm     = data_in & mask_q;
    rm     = ref_q & mask_q;
    result = 1'b0;
    case (mode)
      2'b00:   result = (dm == rm);
      2'b01:   result = (dm != rm);
      2'b10:   result = (dm < rm);
      default: result = (dm > rm);
    endcase
  end

  // Saturating increments for the streak and the total-hit counter.
  always_comb begin
    streak_d    = (streak_q == MAX_STREAK) ? MAX_STREAK : streak_q + STREAK_W'(1);
    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);
  end

  // Control FSM and all registered outputs. locked is kept in step with
  // the LOCKED state, so it changes in the same cycle as the out_valid/hit
  // that caused the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ref_q       <= '0;
      mask_q      <= '1;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      locked_q    <= 1'b0;
      streak_q    <= '0;
      hit_count_q <= '0;
    end else if (load_ref) begin
      state_q     <= ARMED;
      ref_q       <= ref_in;
      mask_q      <= mask_in;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      streak_q    <= '0;
      hit_count_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      hit_q       <= result;
      if (result) begin
        streak_q    <= streak_d;
        hit_count_q <= hit_count_d;
        if (streak_d == MAX_STREAK) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end else begin
          state_q  <= ARMED;
          locked_q <= 1'b0;
        end
      end else begin
        streak_q <= '0;
        state_q  <= ARMED;
        locked_q <= 1'b0;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign streak    = streak_q;
  assign locked    = locked_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_masked_word_match_detector.sv
// Testbench for masked_word_match_detector.
//
// Two instances share one set of inputs:
//   dut  - default parameters (WIDTH=6, MATCH_COUNT=3, CNT_W=8)
//   dut2 - MATCH_COUNT=1, CNT_W=2, used for single-hit lock and counter
//          saturation
//
// A table of per-cycle vectors drives the main sequence. Each row's expected
// outputs are pushed to a queue when it is driven. They are popped and
// compared one cycle later, after the clock edge. Hand-written sequences
// cover counter saturation and the asynchronous reset.

module tb_masked_word_match_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadRef;
  logic [5:0] refIn;
  logic [5:0] maskIn;
  logic [1:0] mode;
  logic       inValid;
  logic [5:0] dataIn;

  logic       outValid,  hit,  locked;
  logic [1:0] streak;
  logic [7:0] hitCount;

  logic       outValid2, hit2, locked2;
  logic [0:0] streak2;
  logic [1:0] hitCount2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       load;
    logic [5:0] refw;
    logic [5:0] mask;
    logic [1:0] mode;
    logic       valid;
    logic [5:0] data;
    logic       eOv;
    logic       eHit;
    int         eStreak;
    logic       eLocked;
    int         eCount;
  } vec_t;

  typedef struct {
    int   row;
    logic eOv;
    logic eHit;
    int   eStreak;
    logic eLocked;
    int   eCount;
  } expect_t;

  expect_t expectQ[$];
  vec_t    vecs[28];

  masked_word_match_detector #(.WIDTH(6), .MATCH_COUNT(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load_ref(loadRef), .ref_in(refIn),
    .mask_in(maskIn), .mode(mode), .in_valid(inValid), .data_in(dataIn),
    .out_valid(outValid), .hit(hit), .streak(streak), .locked(locked),
    .hit_count(hitCount)
  );

  masked_word_match_detector #(.WIDTH(6), .MATCH_COUNT(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .load_ref(loadRef), .ref_in(refIn),
    .mask_in(maskIn), .mode(mode), .in_valid(inValid), .data_in(dataIn),
    .out_valid(outValid2), .hit(hit2), .streak(streak2), .locked(locked2),
    .hit_count(hitCount2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ld, logic [5:0] r, logic [5:0] m,
                              logic [1:0] md, logic v, logic [5:0] d,
                              logic eOv, logic eHit, int eStreak,
                              logic eLocked, int eCount);
    vec_t t;
    t.load = ld;   t.refw = r;    t.mask = m;  t.mode = md;
    t.valid = v;   t.data = d;    t.eOv = eOv; t.eHit = eHit;
    t.eStreak = eStreak; t.eLocked = eLocked; t.eCount = eCount;
    return t;
  endfunction

  task automatic checkField(string name, int actual, int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then wait until just past
  // the next rising edge.
  task automatic driveCycle(logic ld, logic [5:0] r, logic [5:0] m,
                            logic [1:0] md, logic v, logic [5:0] d);
    @(negedge clk);
    loadRef = ld; refIn = r; maskIn = m; mode = md; inValid = v; dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int row);
    expect_t e;
    e.row = row;
    e.eOv = vecs[row].eOv;
    e.eHit = vecs[row].eHit;
    e.eStreak = vecs[row].eStreak;
    e.eLocked = vecs[row].eLocked;
    e.eCount = vecs[row].eCount;
    expectQ.push_back(e);
    driveCycle(vecs[row].load, vecs[row].refw, vecs[row].mask,
               vecs[row].mode, vecs[row].valid, vecs[row].data);
  endtask

  task automatic checkOutput();
    expect_t e;
    if (expectQ.size() == 0) begin
      checkField("scoreboard_empty", 1, 0);
      return;
    end
    e = expectQ.pop_front();
    checkField($sformatf("row%0d_out_valid", e.row), outValid, e.eOv);
    checkField($sformatf("row%0d_hit", e.row), hit, e.eHit);
    checkField($sformatf("row%0d_streak", e.row), streak, e.eStreak);
    checkField($sformatf("row%0d_locked", e.row), locked, e.eLocked);
    checkField($sformatf("row%0d_hit_count", e.row), hitCount, e.eCount);
  endtask

  initial begin
    //          ld  ref    mask   mode  v  data   ov hit st lk cnt
    vecs[0]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h15, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 6'h2A, 6'h3F, 2'b00, 0, 6'h00, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A, 1, 1, 1, 0, 1);
    vecs[3]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A, 1, 1, 2, 0, 2);
    vecs[4]  = mk(0, 6'h00, 6'h00, 2'b00, 0, 6'h2A, 0, 1, 2, 0, 2);
    vecs[5]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A, 1, 1, 3, 1, 3);
    vecs[6]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2B, 1, 0, 0, 0, 3);
    vecs[7]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A, 1, 1, 1, 0, 4);
    vecs[8]  = mk(1, 6'h20, 6'h30, 2'b00, 0, 6'h00, 0, 1, 0, 0, 0);
    vecs[9]  = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2F, 1, 1, 1, 0, 1);
    vecs[10] = mk(0, 6'h00, 6'h00, 2'b10, 1, 6'h1F, 1, 1, 2, 0, 2);
    vecs[11] = mk(0, 6'h00, 6'h00, 2'b11, 1, 6'h3F, 1, 1, 3, 1, 3);
    vecs[12] = mk(0, 6'h00, 6'h00, 2'b11, 1, 6'h20, 1, 0, 0, 0, 3);
    vecs[13] = mk(0, 6'h00, 6'h00, 2'b01, 1, 6'h2A, 1, 0, 0, 0, 3);
    vecs[14] = mk(0, 6'h00, 6'h00, 2'b01, 1, 6'h1F, 1, 1, 1, 0, 4);
    vecs[15] = mk(1, 6'h15, 6'h3F, 2'b00, 1, 6'h15, 0, 1, 0, 0, 0);
    vecs[16] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h15, 1, 1, 1, 0, 1);
    vecs[17] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A, 1, 0, 0, 0, 1);
    vecs[18] = mk(1, 6'h3F, 6'h00, 2'b00, 0, 6'h00, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h12, 1, 1, 1, 0, 1);
    vecs[20] = mk(0, 6'h00, 6'h00, 2'b01, 1, 6'h12, 1, 0, 0, 0, 1);
    vecs[21] = mk(0, 6'h00, 6'h00, 2'b10, 1, 6'h00, 1, 0, 0, 0, 1);
    vecs[22] = mk(0, 6'h00, 6'h00, 2'b11, 1, 6'h3F, 1, 0, 0, 0, 1);
    vecs[23] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h00, 1, 1, 1, 0, 2);
    vecs[24] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h07, 1, 1, 2, 0, 3);
    vecs[25] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h38, 1, 1, 3, 1, 4);
    vecs[26] = mk(0, 6'h00, 6'h00, 2'b00, 1, 6'h21, 1, 1, 3, 1, 5);
    vecs[27] = mk(1, 6'h2A, 6'h3F, 2'b00, 0, 6'h00, 0, 1, 0, 0, 0);

    reset = 1'b1; loadRef = 1'b0; refIn = '0; maskIn = '0; mode = 2'b00;
    inValid = 1'b0; dataIn = '0;
    #12;
    checkField("reset_out_valid", outValid, 0);
    checkField("reset_hit", hit, 0);
    checkField("reset_streak", streak, 0);
    checkField("reset_locked", locked, 0);
    checkField("reset_hit_count", hitCount, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(i);
      checkOutput();
    end

    // MATCH_COUNT=1 instance: every hit locks, and the 2-bit counter holds
    // at 3.
    driveCycle(1, 6'h2A, 6'h3F, 2'b00, 0, 6'h00);
    for (int i = 1; i <= 5; i++) begin
      driveCycle(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A);
      checkField($sformatf("sat_hit%0d_locked2", i), locked2, 1);
      checkField($sformatf("sat_hit%0d_streak2", i), streak2, 1);
      checkField($sformatf("sat_hit%0d_count2", i), hitCount2, (i < 3) ? i : 3);
    end
    driveCycle(0, 6'h00, 6'h00, 2'b00, 1, 6'h2B);
    checkField("sat_miss_locked2", locked2, 0);
    checkField("sat_miss_streak2", streak2, 0);
    checkField("sat_miss_count2", hitCount2, 3);

    // Relock the main instance, then assert reset between edges.
    for (int i = 0; i < 3; i++)
      driveCycle(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A);
    checkField("prereset_locked", locked, 1);
    checkField("prereset_hit_count", hitCount, 8);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkField("async_out_valid", outValid, 0);
    checkField("async_locked", locked, 0);
    checkField("async_streak", streak, 0);
    checkField("async_hit_count", hitCount, 0);
    checkField("async_locked2", locked2, 0);
    #1;
    reset = 1'b0;

    // After reset, the state is IDLE and valid samples produce no result.
    driveCycle(0, 6'h00, 6'h00, 2'b00, 1, 6'h2A);
    checkField("idle_after_reset_out_valid", outValid, 0);
    checkField("idle_after_reset_hit_count", hitCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
